// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with prioritized redirects and a one-entry pending target
// Define PC_SEQ_DELAY_SLOT_EN to insert one sequential delay-slot fetch before each redirect.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [31:0] jump_addr,
    input  logic        branch_valid,
    input  logic [31:0] branch_addr,
    input  logic        jr_valid,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        redirect_pending,
    output logic        misaligned
);

    // ST_PEND: target held, waiting for an advance; ST_SLOT: delay slot is the current fetch
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SLOT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic [31:0] r_tgt;
    logic [31:0] w_next_tgt;
    logic        r_misaligned;

    logic        w_adv;
    logic        w_req;
    logic [31:0] w_sel_addr;
    logic [31:0] w_tgt;
    logic [31:0] w_pc_plus4;

    assign w_adv      = imem_req & imem_ready & ~stall;
    assign w_req      = branch_valid | jr_valid | jump_valid;
    assign w_sel_addr = branch_valid ? branch_addr :
                        jr_valid     ? jr_addr     : jump_addr;
    assign w_tgt      = {w_sel_addr[31:2], 2'b00};
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_tgt        <= 32'h0000_0000;
            r_misaligned <= 1'b0;
        end else begin
            r_pc  <= w_next_pc;
            r_tgt <= w_next_tgt;
            if (w_req && (w_sel_addr[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_tgt   = r_tgt;
`ifdef PC_SEQ_DELAY_SLOT_EN
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_tgt = w_tgt;
                    if (w_adv) begin
                        w_next_pc    = w_pc_plus4;
                        w_next_state = ST_SLOT;
                    end else begin
                        w_next_state = ST_PEND;
                    end
                end else if (w_adv) begin
                    w_next_pc = w_pc_plus4;
                end
            end
            ST_PEND: begin
                if (w_req) begin
                    w_next_tgt = w_tgt;
                end
                if (w_adv) begin
                    w_next_pc    = w_pc_plus4;
                    w_next_state = ST_SLOT;
                end
            end
            ST_SLOT: begin
                // a request here only retargets; the slot already in flight is not restarted
                if (w_req) begin
                    w_next_tgt = w_tgt;
                end
                if (w_adv) begin
                    w_next_pc    = w_req ? w_tgt : r_tgt;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
`else
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_adv) begin
                        w_next_pc = w_tgt;
                    end else begin
                        w_next_tgt   = w_tgt;
                        w_next_state = ST_PEND;
                    end
                end else if (w_adv) begin
                    w_next_pc = w_pc_plus4;
                end
            end
            ST_PEND: begin
                if (w_req) begin
                    w_next_tgt = w_tgt;
                end
                if (w_adv) begin
                    w_next_pc    = w_req ? w_tgt : r_tgt;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
`endif
    end

    always_comb begin
        imem_req         = rst_n;
        pc               = r_pc;
        pc_plus4         = w_pc_plus4;
        redirect_pending = (r_state != ST_IDLE);
        misaligned       = r_misaligned;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer (default build, no delay slot)
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jump_valid;
    logic [31:0] jump_addr;
    logic        branch_valid;
    logic [31:0] branch_addr;
    logic        jr_valid;
    logic [31:0] jr_addr;
    logic        imem_ready;
    logic        imem_req,  imem_req2;
    logic [31:0] pc,        pc2;
    logic [31:0] pc_plus4,  pc_plus4_2;
    logic        redirect_pending, redirect_pending2;
    logic        misaligned, misaligned2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .branch_valid(branch_valid), .branch_addr(branch_addr),
        .jr_valid(jr_valid), .jr_addr(jr_addr),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .pc(pc), .pc_plus4(pc_plus4),
        .redirect_pending(redirect_pending), .misaligned(misaligned)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .branch_valid(branch_valid), .branch_addr(branch_addr),
        .jr_valid(jr_valid), .jr_addr(jr_addr),
        .imem_req(imem_req2), .imem_ready(imem_ready),
        .pc(pc2), .pc_plus4(pc_plus4_2),
        .redirect_pending(redirect_pending2), .misaligned(misaligned2)
    );

    task automatic clear_reqs();
        jump_valid = 1'b0; branch_valid = 1'b0; jr_valid = 1'b0;
        jump_addr = 32'h0; branch_addr = 32'h0; jr_addr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
        clear_reqs();
        repeat (2) @(negedge clk);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (pc2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL reset_pc_hi got=%h exp=%h", pc2, 32'hFFFF_FFF8); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b exp=0", redirect_pending); end
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
        total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=%h", pc_plus4, 32'h4); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_lo [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] exp_hi [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL run_req[%0d] got=%b exp=1", i, imem_req); end
            total++; if (pc !== exp_lo[i]) begin bad++; $display("FAIL run_pc[%0d] got=%h exp=%h", i, pc, exp_lo[i]); end
            total++; if (pc2 !== exp_hi[i]) begin bad++; $display("FAIL run_pc_hi[%0d] got=%h exp=%h", i, pc2, exp_hi[i]); end
        end
    endtask

    task automatic test_jump();
        jump_valid = 1'b1; jump_addr = 32'h0000_0100;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL jump_setup got=%h exp=%h", pc, 32'h100); end
        total++; if (pc_plus4 !== 32'h104) begin bad++; $display("FAIL jump_pc4 got=%h exp=%h", pc_plus4, 32'h104); end
        jump_valid = 1'b1; jump_addr = 32'h0040_0020;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h0040_0020) begin bad++; $display("FAIL jump_tgt got=%h exp=%h", pc, 32'h0040_0020); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL jump_pend got=%b exp=0", redirect_pending); end
        @(negedge clk);
        total++; if (pc !== 32'h0040_0024) begin bad++; $display("FAIL jump_seq got=%h exp=%h", pc, 32'h0040_0024); end
    endtask

    task automatic test_stall_capture();
        stall = 1'b1; branch_valid = 1'b1; branch_addr = 32'h200;
        @(negedge clk);
        clear_reqs();
        total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL stall1_pend got=%b exp=1", redirect_pending); end
        total++; if (pc !== 32'h0040_0024) begin bad++; $display("FAIL stall1_pc got=%h exp=%h", pc, 32'h0040_0024); end
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL stall1_req got=%b exp=1", imem_req); end
        jump_valid = 1'b1; jump_addr = 32'h300;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h0040_0024) begin bad++; $display("FAIL stall2_pc got=%h exp=%h", pc, 32'h0040_0024); end
        @(negedge clk);
        total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL stall3_pend got=%b exp=1", redirect_pending); end
        total++; if (pc !== 32'h0040_0024) begin bad++; $display("FAIL stall3_pc got=%h exp=%h", pc, 32'h0040_0024); end
        stall = 1'b0;
        @(negedge clk);
        total++; if (pc !== 32'h300) begin bad++; $display("FAIL stall_apply got=%h exp=%h", pc, 32'h300); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL stall_clear got=%b exp=0", redirect_pending); end
        @(negedge clk);
        total++; if (pc !== 32'h304) begin bad++; $display("FAIL stall_seq got=%h exp=%h", pc, 32'h304); end
    endtask

    task automatic test_priority();
        branch_valid = 1'b1; branch_addr = 32'h500;
        jr_valid = 1'b1; jr_addr = 32'h600;
        jump_valid = 1'b1; jump_addr = 32'h700;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h500) begin bad++; $display("FAIL prio_all got=%h exp=%h", pc, 32'h500); end
        jr_valid = 1'b1; jr_addr = 32'h600;
        jump_valid = 1'b1; jump_addr = 32'h700;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h600) begin bad++; $display("FAIL prio_jr got=%h exp=%h", pc, 32'h600); end
        imem_ready = 1'b0; jump_valid = 1'b1; jump_addr = 32'h800;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h600) begin bad++; $display("FAIL notready_pc got=%h exp=%h", pc, 32'h600); end
        total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL notready_pend got=%b exp=1", redirect_pending); end
        imem_ready = 1'b1; jr_valid = 1'b1; jr_addr = 32'h900;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h900) begin bad++; $display("FAIL latest_wins got=%h exp=%h", pc, 32'h900); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL latest_pend got=%b exp=0", redirect_pending); end
    endtask

    task automatic test_misaligned();
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_pre got=%b exp=0", misaligned); end
        jr_valid = 1'b1; jr_addr = 32'h0000_1003;
        @(negedge clk);
        clear_reqs();
        total++; if (pc !== 32'h1000) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h1000); end
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_set got=%b exp=1", misaligned); end
        repeat (3) @(negedge clk);
        total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", misaligned); end
        total++; if (pc !== 32'h100C) begin bad++; $display("FAIL mis_seq got=%h exp=%h", pc, 32'h100C); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misaligned); end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        jump_valid = 1'b1; jump_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        clear_reqs();
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=%h", pc_plus4, 32'h0); end
        @(negedge clk);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
    endtask

    task automatic test_reset_pending();
        stall = 1'b1; branch_valid = 1'b1; branch_addr = 32'h40;
        @(negedge clk);
        clear_reqs();
        total++; if (redirect_pending !== 1'b1) begin bad++; $display("FAIL rp_pend got=%b exp=1", redirect_pending); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL rp_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (pc2 !== 32'hFFFF_FFF8) begin bad++; $display("FAIL rp_pc_hi got=%h exp=%h", pc2, 32'hFFFF_FFF8); end
        total++; if (redirect_pending !== 1'b0) begin bad++; $display("FAIL rp_clear got=%b exp=0", redirect_pending); end
        total++; if (redirect_pending2 !== 1'b0) begin bad++; $display("FAIL rp_clear_hi got=%b exp=0", redirect_pending2); end
        @(negedge clk);
        stall = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        total++; if (pc !== 32'h4) begin bad++; $display("FAIL rp_discard got=%h exp=%h", pc, 32'h4); end
        total++; if (pc2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rp_discard_hi got=%h exp=%h", pc2, 32'hFFFF_FFFC); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_jump();
        test_stall_capture();
        test_priority();
        test_misaligned();
        test_wrap();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
